// File: rtl/mul_acc_frame.sv
// Frame accumulator for multiplier products: sums N products per frame and offers each sum on a valid/ready port.
// Optional macro ACC_SAT_EN: clamp the running sum at all-ones and raise a sticky acc_sat flag.
module mul_acc_frame #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 36,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mul_en_out,
    input  logic [DATA_W-1:0] mul_out,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              clr,
    input  logic              acc_ready,
    output logic              acc_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_busy,
    output logic              drop_err,
    output logic              acc_sat
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [LEN_W-1:0]  len_eff, cnt_inc;
    logic [ACC_W-1:0]  sum;
    logic              add_fire, start;

    // A zero frame length behaves as a single-product frame.
    assign len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
    assign cnt_inc = cnt_q + LEN_W'(1);

`ifdef ACC_SAT_EN
    logic [ACC_W:0] sum_full;
    logic           sat_q;

    assign sum_full = {1'b0, acc_q} + (ACC_W+1)'(mul_out);
    assign sum      = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else if (clr)
            sat_q <= 1'b0;
        else if (add_fire && sum_full[ACC_W])
            sat_q <= 1'b1;
    end

    assign acc_sat = sat_q;
`else
    assign sum     = acc_q + ACC_W'(mul_out);
    assign acc_sat = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        start    = 1'b0;
        add_fire = 1'b0;
        drop_err = 1'b0;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: start = mul_en_out;
                ACC: begin
                    if (mul_en_out) begin
                        add_fire = 1'b1;
                        acc_d    = sum;
                        cnt_d    = cnt_inc;
                        if (cnt_inc == len_q)
                            state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (acc_ready) begin
                        if (mul_en_out)
                            start = 1'b1;
                        else
                            state_d = IDLE;
                    end else if (mul_en_out) begin
                        drop_err = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // A product accepted from IDLE or on a HOLD transfer opens a new frame.
            if (start) begin
                acc_d   = ACC_W'(mul_out);
                cnt_d   = LEN_W'(1);
                len_d   = len_eff;
                state_d = (len_eff == LEN_W'(1)) ? HOLD : ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign acc_valid = (state_q == HOLD);
    assign acc_busy  = (state_q == ACC);
    assign acc_out   = acc_q;

endmodule

// File: tb/tb_mul_acc_frame.sv
// Directed bench for mul_acc_frame: hand-computed frame sums, drop, clear, reset and frame-length cases.
module tb_mul_acc_frame;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mul_en_out = 1'b0;
    logic [31:0] mul_out = '0;
    logic [7:0]  frame_len = '0;
    logic        clr = 1'b0;
    logic        acc_ready = 1'b0;
    logic        acc_valid;
    logic [35:0] acc_out;
    logic        acc_busy;
    logic        drop_err;
    logic        acc_sat;

    int total = 0;
    int bad = 0;

    mul_acc_frame dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_en_out (mul_en_out),
        .mul_out    (mul_out),
        .frame_len  (frame_len),
        .clr        (clr),
        .acc_ready  (acc_ready),
        .acc_valid  (acc_valid),
        .acc_out    (acc_out),
        .acc_busy   (acc_busy),
        .drop_err   (drop_err),
        .acc_sat    (acc_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        mul_en_out = 1'b1;
        mul_out    = d;
        tick();
        mul_en_out = 1'b0;
    endtask

    logic [35:0] exp_big;
    logic        exp_sat;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", acc_valid, 0);
        chk("rst_out", acc_out, 0);
        chk("rst_busy", acc_busy, 0);
        chk("rst_drop", drop_err, 0);
        chk("rst_sat", acc_sat, 0);
        #2 rst_n = 1'b1;
        tick();

        // Four-product frame, ready high
        frame_len = 8'd4;
        acc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mul_en_out = 1'b1;
            mul_out    = 32'd200000000;
            #1 chk("f4_nodrop", drop_err, 0);
            @(posedge clk);
            #1;
            if (i < 3) begin
                chk("f4_busy", acc_busy, 1);
                chk("f4_novalid", acc_valid, 0);
            end
        end
        mul_en_out = 1'b0;
        chk("f4_valid", acc_valid, 1);
        chk("f4_sum", acc_out, 36'd800000000);
        chk("f4_notbusy", acc_busy, 0);
        tick();
        chk("f4_pulse_end", acc_valid, 0);

        // Length-1 frames back to back
        frame_len = 8'd1;
        strobe(32'd5);
        chk("l1_v0", acc_valid, 1);
        chk("l1_s0", acc_out, 5);
        mul_en_out = 1'b1;
        mul_out    = 32'd7;
        #1 chk("l1_nodrop", drop_err, 0);
        tick();
        chk("l1_v1", acc_valid, 1);
        chk("l1_s1", acc_out, 7);
        mul_out = 32'd9;
        tick();
        mul_en_out = 1'b0;
        chk("l1_v2", acc_valid, 1);
        chk("l1_s2", acc_out, 9);
        tick();
        chk("l1_end", acc_valid, 0);

        // Backpressure drop
        frame_len = 8'd2;
        acc_ready = 1'b0;
        strobe(32'd3);
        chk("bp_busy", acc_busy, 1);
        strobe(32'd4);
        chk("bp_valid", acc_valid, 1);
        chk("bp_sum", acc_out, 7);
        mul_en_out = 1'b1;
        mul_out    = 32'd99;
        #1 chk("bp_drop", drop_err, 1);
        tick();
        mul_en_out = 1'b0;
        #1 chk("bp_drop_end", drop_err, 0);
        chk("bp_held", acc_out, 7);
        chk("bp_still_valid", acc_valid, 1);
        acc_ready = 1'b1;
        tick();
        chk("bp_xfer", acc_valid, 0);
        chk("bp_idle", acc_busy, 0);

        // Seventeen all-ones products
`ifdef ACC_SAT_EN
        exp_big = 36'hF_FFFF_FFFF;
        exp_sat = 1'b1;
`else
        exp_big = 36'h0_FFFF_FFEF;
        exp_sat = 1'b0;
`endif
        frame_len = 8'd17;
        acc_ready = 1'b0;
        for (int i = 0; i < 17; i++) strobe(32'hFFFF_FFFF);
        chk("big_valid", acc_valid, 1);
        chk("big_sum", acc_out, exp_big);
        chk("big_sat", acc_sat, exp_sat);
        acc_ready = 1'b1;
        tick();
        chk("big_xfer", acc_valid, 0);
        chk("big_sat_sticky", acc_sat, exp_sat);

        // Clear with coincident strobe
        frame_len = 8'd4;
        strobe(32'd1);
        strobe(32'd1);
        chk("clr_pre_busy", acc_busy, 1);
        clr        = 1'b1;
        mul_en_out = 1'b1;
        mul_out    = 32'd1;
        #1 chk("clr_nodrop", drop_err, 0);
        tick();
        clr        = 1'b0;
        mul_en_out = 1'b0;
        chk("clr_busy", acc_busy, 0);
        chk("clr_valid", acc_valid, 0);
        chk("clr_acc", acc_out, 0);
        chk("clr_sat", acc_sat, 0);
        for (int i = 0; i < 4; i++) strobe(32'd1);
        chk("clr_new_valid", acc_valid, 1);
        chk("clr_new_sum", acc_out, 4);
        tick();

        // Async reset mid-frame
        strobe(32'd10);
        strobe(32'd10);
        chk("ar_pre_busy", acc_busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_busy", acc_busy, 0);
        chk("ar_out", acc_out, 0);
        chk("ar_valid", acc_valid, 0);
        #2 rst_n = 1'b1;
        tick();

        // Mid-frame frame_len change is ignored
        frame_len = 8'd4;
        strobe(32'd10);
        frame_len = 8'd2;
        strobe(32'd10);
        chk("fl_busy", acc_busy, 1);
        chk("fl_novalid", acc_valid, 0);
        strobe(32'd10);
        strobe(32'd10);
        chk("fl_valid", acc_valid, 1);
        chk("fl_sum", acc_out, 40);
        tick();

        // Zero frame length acts as one
        frame_len = 8'd0;
        strobe(32'd6);
        chk("z_valid", acc_valid, 1);
        chk("z_sum", acc_out, 6);
        tick();
        chk("z_end", acc_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
